// File: rtl/mod_ctrl_pkg.sv
// Shared encodings for the modulator front-panel key controller.
// Mode codes, key identifiers and FSM states used by mod_key_ctrl.
package mod_ctrl_pkg;

    localparam logic [1:0] MODE_ASK = 2'b00;
    localparam logic [1:0] MODE_FSK = 2'b01;
    localparam logic [1:0] MODE_PSK = 2'b10;

    typedef enum logic [1:0] {
        KEY_NONE = 2'd0,
        KEY_MODE = 2'd1,
        KEY_UP   = 2'd2,
        KEY_DN   = 2'd3
    } key_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    function automatic logic [1:0] next_mode(input logic [1:0] cur);
        case (cur)
            MODE_ASK: next_mode = MODE_FSK;
            MODE_FSK: next_mode = MODE_PSK;
            default:  next_mode = MODE_ASK;
        endcase
    endfunction

endpackage

// File: rtl/mod_key_ctrl_hold_timer.sv
// Loadable 24-bit down-counter with a zero flag for key hold / repeat timing.
// Load wins over enable, and the count never wraps below zero.
module hold_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mod_key_ctrl.sv
// Front-panel key controller: arbitrates MODE/UP/DOWN presses into mode and freq_sel.
// Define MOD_KEY_AUTO_REPEAT_EN to build UP/DOWN auto-repeat while a key is held.
module mod_key_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter logic [23:0] HOLD_CYC   = 24'd5_000_000,
    parameter logic [23:0] REPEAT_CYC = 24'd1_000_000,
    parameter logic [3:0]  FREQ_MAX   = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_dn,
    output logic [1:0] mode,
    output logic [3:0] freq_sel,
    output logic       cfg_valid,
    output logic       busy
);

    state_t      r_state;
    state_t      w_state_next;
    key_t        r_key;
    key_t        w_win;
    key_t        w_act_key;
    logic [1:0]  r_mode;
    logic [3:0]  r_freq;
    logic        r_cfg_valid;
    logic [1:0]  w_mode_next;
    logic [3:0]  w_freq_next;
    logic        w_change;
    logic        w_any;
    logic        w_all_high;
    logic        w_held;
    logic        w_load;
    logic [23:0] w_load_val;
    logic        w_dec;
    logic        w_cnt_zero;

    assign w_any      = !key_mode || !key_up || !key_dn;
    assign w_all_high = key_mode && key_up && key_dn;

    always_comb begin
        if (!key_mode)    w_win = KEY_MODE;
        else if (!key_up) w_win = KEY_UP;
        else if (!key_dn) w_win = KEY_DN;
        else              w_win = KEY_NONE;
    end

    // Only the latched key keeps HOLD alive; other keys are ignored there.
    always_comb begin
        case (r_key)
            KEY_MODE: w_held = !key_mode;
            KEY_UP:   w_held = !key_up;
            KEY_DN:   w_held = !key_dn;
            default:  w_held = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_RELEASE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_any)      w_state_next = ST_HOLD;
            ST_HOLD:    if (!w_held)    w_state_next = ST_RELEASE;
            ST_RELEASE: if (w_all_high) w_state_next = ST_IDLE;
            default:                    w_state_next = ST_RELEASE;
        endcase
    end

    always_comb begin
        w_act_key  = KEY_NONE;
        w_load     = 1'b0;
        w_load_val = HOLD_CYC - 24'd1;
        w_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_act_key = w_win;
                    w_load    = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_held) begin
`ifdef MOD_KEY_AUTO_REPEAT_EN
                    if (w_cnt_zero && (r_key == KEY_UP || r_key == KEY_DN)) begin
                        w_act_key  = r_key;
                        w_load     = 1'b1;
                        w_load_val = REPEAT_CYC - 24'd1;
                    end else begin
                        w_dec = !w_cnt_zero;
                    end
`else
                    w_dec = !w_cnt_zero;
`endif
                end
            end
            default: ;
        endcase
    end

    // Saturated steps leave the value alone and raise no strobe.
    always_comb begin
        w_mode_next = r_mode;
        w_freq_next = r_freq;
        w_change    = 1'b0;
        case (w_act_key)
            KEY_MODE: begin
                w_mode_next = next_mode(r_mode);
                w_change    = 1'b1;
            end
            KEY_UP: begin
                if (r_freq < FREQ_MAX) begin
                    w_freq_next = r_freq + 4'd1;
                    w_change    = 1'b1;
                end
            end
            KEY_DN: begin
                if (r_freq != 4'd0) begin
                    w_freq_next = r_freq - 4'd1;
                    w_change    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode      <= MODE_ASK;
            r_freq      <= 4'd0;
            r_cfg_valid <= 1'b0;
            r_key       <= KEY_NONE;
        end else begin
            r_mode      <= w_mode_next;
            r_freq      <= w_freq_next;
            r_cfg_valid <= w_change;
            if (r_state == ST_IDLE && w_any) r_key <= w_win;
        end
    end

    hold_timer #(.W(24)) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_dec),
        .o_zero     (w_cnt_zero)
    );

    assign mode      = r_mode;
    assign freq_sel  = r_freq;
    assign cfg_valid = r_cfg_valid;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mod_key_ctrl.sv
// Directed self-checking bench for mod_key_ctrl (HOLD_CYC=8, REPEAT_CYC=4, FREQ_MAX=9).
// Define MOD_KEY_AUTO_REPEAT_EN for both bench and RTL to check the repeat build.
module tb_mod_key_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode;
    logic       key_up;
    logic       key_dn;
    logic [1:0] mode;
    logic [3:0] freq_sel;
    logic       cfg_valid;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int p0;
    int exp_freq;
    int exp_mode;

    mod_key_ctrl #(
        .HOLD_CYC   (24'd8),
        .REPEAT_CYC (24'd4),
        .FREQ_MAX   (4'd9)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_up    (key_up),
        .key_dn    (key_dn),
        .mode      (mode),
        .freq_sel  (freq_sel),
        .cfg_valid (cfg_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cfg_valid === 1'b1) pulses++;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            1: key_mode = v;
            2: key_up   = v;
            default: key_dn = v;
        endcase
    endtask

    // One short press: low for a single sample, then release back to IDLE.
    task automatic tap(input string tag, input int k, input int e_mode, input int e_freq, input int e_valid);
        set_key(k, 1'b0);
        tick();
        check({tag, ".mode"},  int'(mode), e_mode);
        check({tag, ".freq"},  int'(freq_sel), e_freq);
        check({tag, ".valid"}, int'(cfg_valid), e_valid);
        set_key(k, 1'b1);
        tick();
        tick();
        check({tag, ".idle"}, int'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; key_mode = 1'b1; key_up = 1'b0; key_dn = 1'b1;
        repeat (3) tick();
        check("rst.mode", int'(mode), 0);
        check("rst.freq", int'(freq_sel), 0);
        check("rst.valid", int'(cfg_valid), 0);
        check("rst.busy", int'(busy), 1);

        // UP held through reset must not act
        rst_n = 1'b1;
        p0 = pulses;
        repeat (5) tick();
        check("hold_thru_rst.freq", int'(freq_sel), 0);
        check("hold_thru_rst.pulses", pulses - p0, 0);
        check("hold_thru_rst.busy", int'(busy), 1);
        key_up = 1'b1;
        tick();
        check("hold_thru_rst.idle", int'(busy), 0);
        tap("up_after_rst", 2, 0, 1, 1);
        exp_freq = 1;

        p0 = pulses;
        tap("mode1", 1, 1, exp_freq, 1);
        tap("mode2", 1, 2, exp_freq, 1);
        tap("mode3", 1, 0, exp_freq, 1);
        check("mode.pulses", pulses - p0, 3);

        // simultaneous MODE+UP: only MODE acts
        p0 = pulses;
        key_mode = 1'b0; key_up = 1'b0;
        tick();
        check("simul.mode", int'(mode), 1);
        check("simul.freq", int'(freq_sel), exp_freq);
        key_mode = 1'b1;
        tick();
        key_dn = 1'b0;
        repeat (4) tick();
        check("lockout.freq", int'(freq_sel), exp_freq);
        check("lockout.busy", int'(busy), 1);
        key_up = 1'b1; key_dn = 1'b1;
        tick();
        check("lockout.idle", int'(busy), 0);
        check("simul.pulses", pulses - p0, 1);
        exp_mode = 1;

        for (int i = 0; i < 8; i++) begin
            exp_freq++;
            tap($sformatf("up%0d", i), 2, exp_mode, exp_freq, 1);
        end
        p0 = pulses;
        tap("up_sat", 2, exp_mode, 9, 0);
        check("up_sat.pulses", pulses - p0, 0);
        for (int i = 0; i < 9; i++) begin
            exp_freq--;
            tap($sformatf("dn%0d", i), 3, exp_mode, exp_freq, 1);
        end
        p0 = pulses;
        tap("dn_sat", 3, exp_mode, 0, 0);
        check("dn_sat.pulses", pulses - p0, 0);

        // long UP hold from freq_sel = 0
        p0 = pulses;
        key_up = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
`ifdef MOD_KEY_AUTO_REPEAT_EN
            exp_freq = 1 + int'(c >= 9) + int'(c >= 13) + int'(c >= 17);
`else
            exp_freq = 1;
`endif
            check($sformatf("hold.c%0d", c), int'(freq_sel), exp_freq);
        end
        key_up = 1'b1;
        tick();
        tick();
`ifdef MOD_KEY_AUTO_REPEAT_EN
        check("hold.pulses", pulses - p0, 4);
`else
        check("hold.pulses", pulses - p0, 1);
`endif
        check("hold.idle", int'(busy), 0);

        // reset while held mid-repeat
        key_up = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        check("midrst.mode", int'(mode), 0);
        check("midrst.freq", int'(freq_sel), 0);
        check("midrst.valid", int'(cfg_valid), 0);
        check("midrst.busy", int'(busy), 1);
        rst_n = 1'b1;
        repeat (2) tick();
        check("midrst.held_busy", int'(busy), 1);
        check("midrst.held_freq", int'(freq_sel), 0);
        key_up = 1'b1;
        tick();
        check("midrst.idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
